// File: rtl/mem_arbiter_if.sv
// Bundled request/response signals for mem_arbiter: fetch port, data port and shared memory port.
// master = arbiter view, slave = requesters plus memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req_valid;
    logic [ADDR_W-1:0]     if_req_addr;
    logic                  if_req_ready;
    logic                  if_rsp_valid;
    logic [DATA_W-1:0]     if_rsp_data;

    logic                  d_req_valid;
    logic [ADDR_W-1:0]     d_req_addr;
    logic                  d_req_we;
    logic [DATA_W-1:0]     d_req_wdata;
    logic [DATA_W/8-1:0]   d_req_wstrb;
    logic                  d_req_ready;
    logic                  d_rsp_valid;
    logic [DATA_W-1:0]     d_rsp_data;

    logic                  mem_req_valid;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_we;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wstrb;
    logic                  mem_req_ready;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_data;

    modport master (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between a fetch and a data requester, one transaction in flight.
// Define MEM_ARBITER_ROUND_ROBIN_EN for alternating grants on conflict; otherwise data always wins.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.master  bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    state_t              state_next;
    logic                grant_if;
    logic                grant_d;
    logic                owner_data;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                if_rsp_pulse;
    logic                d_rsp_pulse;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_data;

    // On conflict the requester that did not win last time gets the port.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE) begin
            if (bus.if_req_valid && bus.d_req_valid) begin
                grant_d  = !last_data;
                grant_if = last_data;
            end else begin
                grant_d  = bus.d_req_valid;
                grant_if = bus.if_req_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_data <= 1'b0;
        end else if (grant_if || grant_d) begin
            last_data <= grant_d;
        end
    end
`else
    assign grant_d  = (state == IDLE) && bus.d_req_valid;
    assign grant_if = (state == IDLE) && bus.if_req_valid && !bus.d_req_valid;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        bus.if_req_ready  = 1'b0;
        bus.d_req_ready   = 1'b0;
        bus.mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.if_req_ready = grant_if;
                bus.d_req_ready  = grant_d;
                if (grant_if || grant_d) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fetches never write, so their write fields are forced to zero when latched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_data   <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rsp_data_q   <= '0;
            if_rsp_pulse <= 1'b0;
            d_rsp_pulse  <= 1'b0;
        end else begin
            if_rsp_pulse <= (state == WAIT) && bus.mem_rsp_valid && !owner_data;
            d_rsp_pulse  <= (state == WAIT) && bus.mem_rsp_valid && owner_data;
            if ((state == WAIT) && bus.mem_rsp_valid) begin
                rsp_data_q <= bus.mem_rsp_data;
            end
            if (grant_d) begin
                owner_data <= 1'b1;
                addr_q     <= bus.d_req_addr;
                we_q       <= bus.d_req_we;
                wdata_q    <= bus.d_req_wdata;
                wstrb_q    <= bus.d_req_wstrb;
            end else if (grant_if) begin
                owner_data <= 1'b0;
                addr_q     <= bus.if_req_addr;
                we_q       <= 1'b0;
                wdata_q    <= '0;
                wstrb_q    <= '0;
            end
        end
    end

    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wstrb = wstrb_q;
    assign bus.if_rsp_valid  = if_rsp_pulse;
    assign bus.d_rsp_valid   = d_rsp_pulse;
    assign bus.if_rsp_data   = rsp_data_q;
    assign bus.d_rsp_data    = rsp_data_q;
endmodule
